// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and frame constants for the FIFO-fed serial transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: a down-counter that raises bit_done for one cycle every CLKS_PER_BIT cycles.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Clearing reloads the full period so the first tick lands CLKS_PER_BIT cycles later.
  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (clear || (cnt_q == 16'd0)) begin
      cnt_d = RELOAD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == 16'd0);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte at a time and sends it as an 8N1 frame on txd.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = fifo_uart_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rn,
  output logic              txd,
  output logic              busy,
  output logic [15:0]       frame_count
);

  import fifo_uart_pkg::*;

  // Index of the final data bit: everything in a frame except start and stop.
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              txd_q, txd_d;
  logic              fifo_rn_q, fifo_rn_d;
  logic              busy_q, busy_d;
  logic              bit_done;
  logic              baud_clear;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    frame_count_d = frame_count_q;
    baud_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d    = fifo_data;
        baud_clear = 1'b1;
        state_d    = START;
      end
      START: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the pins come straight from flops.
    fifo_rn_d = (state_d == POP);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_idx_q     <= 3'd0;
      frame_count_q <= 16'd0;
      txd_q         <= 1'b1;
      fifo_rn_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      frame_count_q <= frame_count_d;
      txd_q         <= txd_d;
      fifo_rn_q     <= fifo_rn_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo_rn     = fifo_rn_q;
  assign txd         = txd_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's 8-bit synchronous FIFO. It pops bytes through the FIFO's read-enable/empty handshake and serialises each byte as an asynchronous serial frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single output line. It sits between the FIFO's read port and the chip's serial transmit pin, and drains the FIFO while enabled.

## Interface
Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535
- DATA_W, 8, byte width; fixed at 8 and must match the FIFO width

Ports:
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits starting a new frame; sampled only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO DATAOUT; valid on the cycle after a pop edge
- fifo_rn  out  1  FIFO read enable; registered, high for exactly one cycle per pop
- txd  out  1  serial line; idle high
- busy  out  1  high from pop until end of stop bit
- frame_count  out  16  frames completed since reset; wraps modulo 2^16

## Operation
- Reset values: txd=1, fifo_rn=0, busy=0, frame_count=0, state=IDLE, bit counter and baud counter 0.
- States: IDLE -> POP -> LOAD -> START -> DATA -> STOP -> IDLE.
- IDLE: txd=1. If enable && !fifo_empty, go to POP. Otherwise stay in IDLE.
- POP: fifo_rn=1 for this single cycle. Go to LOAD.
- LOAD: capture fifo_data into the 8-bit shift register. Go to START.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: txd=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. On the last cycle, increment frame_count, then go to IDLE.
- fifo_rn is never asserted while fifo_empty=1. It is asserted only from IDLE, so no pop occurs while a frame is in flight.
- Deasserting enable mid-frame does not abort the frame. The current frame completes and no new pop occurs.
- Reset asserted in any state takes effect on the next edge: the frame is abandoned, txd=1, and the popped byte is lost. No further pop occurs until reset is released.
- frame_count wraps from 16'hFFFF to 0.

## Timing
- Let k be the edge at which IDLE sees enable && !fifo_empty.
  - After edge k: fifo_rn=1 and busy=1.
  - Edge k+1: the FIFO presents the byte.
  - Edge k+2: the byte is latched and txd falls (start bit).
- Start bit: edges k+2 .. k+2+CLKS_PER_BIT.
- Data bit i: edges k+2+(i+1)·CLKS_PER_BIT onwards, each CLKS_PER_BIT cycles long.
- The stop bit ends and the block returns to IDLE at edge k+2+10·CLKS_PER_BIT. busy and frame_count update at this same edge.
- Back-to-back frames with the FIFO non-empty have a period of 10·CLKS_PER_BIT+3 cycles (43 at the default).
- txd, fifo_rn and busy are register outputs with no combinational paths from inputs.

## Structure
- Shared package fifo_uart_pkg:
  - state enum (IDLE, POP, LOAD, START, DATA, STOP)
  - FRAME_BITS=10
  - DATA_W=8
- Sub-module baud_tick_gen: a CLKS_PER_BIT down-counter with a synchronous clear.
  - It is cleared on entry to START.
  - It outputs a one-cycle bit_done tick.
  - The FSM, shift register and frame counter stay in fifo_uart_tx.

## Test plan
- Reset with FIFO empty and enable=1, run 100 cycles -> fifo_rn stays 0, txd stays 1, busy=0, frame_count=0.
- Write 8'd100 into the FIFO, enable=1, CLKS_PER_BIT=4:
  - fifo_rn pulses for 1 cycle.
  - txd bit sequence, sampled mid-bit, is 0, 0,0,1,0,0,1,1,0, 1.
  - frame_count=1 and busy=0 at k+42.
- Write 100, 150, 200, 40, 70, 65, 15 and enable:
  - 7 frames decode in order.
  - Consecutive start bits are 43 cycles apart.
  - fifo_rn pulses exactly 7 times, then empty=1, and frame_count=7.
- Enable dropped during the DATA bit 3 of byte 8'hA5 with 3 bytes queued -> the A5 frame completes intact, then there are no further pops and the FIFO retains 2 bytes.
- Reset asserted for 1 cycle mid-DATA -> next edge txd=1, busy=0, frame_count=0. After release with the FIFO non-empty, a new frame starts with a clean start bit.
- Preload frame_count near wrap (force 16'hFFFF via 65535 frames at CLKS_PER_BIT=2, or hierarchical deposit), send 1 byte -> frame_count=0.
